hwpe_stream_fifo_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one hwpe-stream FIFO push port between N_INPUTS requester streams.

---
 rtl/hwpe_stream_fifo_rr_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_hwpe_stream_fifo_rr_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_fifo_rr_arbiter.sv
// -----------------------------------------------------------------------------
// hwpe_stream_fifo_rr_arbiter
//
// Round-robin arbiter that shares one hwpe-stream FIFO push port between
// N_INPUTS requester streams. The winning beat and the winner index are
// registered, so the FIFO push side sees clean registered outputs. The
// register stage loads and drains in the same cycle, which sustains one beat
// per cycle.
//
// Optional feature macro: HWPE_ARB_BURST_LOCK_EN
//   When defined, a requester that wins keeps the grant for up to BURST_LEN
//   consecutive beats. The lock is released early if that requester drops
//   in_valid while the output stage can accept a beat.
//
// Parameters
//   N_INPUTS   number of requester streams (>= 1)
//   DATA_WIDTH beat width in bits (multiple of 8)
//   BURST_LEN  maximum beats per grant while burst locking is enabled (>= 1)
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   clear      synchronous clear, same effect as reset
//   in_valid   per-requester valid                      [N_INPUTS]
//   in_ready   per-requester ready, at most one bit set [N_INPUTS]
//   in_data    requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_strb    requester i at [i*DATA_WIDTH/8 +: DATA_WIDTH/8]
//   out_valid  FIFO push valid (registered)
//   out_ready  FIFO push ready
//   out_data   FIFO push data (registered)
//   out_strb   FIFO push strobe (registered)
//   out_sel    index of the requester owning the current out beat (registered)
// -----------------------------------------------------------------------------
module hwpe_stream_fifo_rr_arbiter #(
    parameter  int N_INPUTS   = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int BURST_LEN  = 4,
    localparam int SEL_W      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [N_INPUTS-1:0]          in_valid,
    output logic [N_INPUTS-1:0]          in_ready,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [N_INPUTS*STRB_W-1:0]   in_strb,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [STRB_W-1:0]            out_strb,
    output logic [SEL_W-1:0]             out_sel
);

    // Reject illegal configurations at elaboration time.
    if (N_INPUTS < 1 || (DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || BURST_LEN < 1) begin : g_param_check
        $error("hwpe_stream_fifo_rr_arbiter: illegal parameter combination");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [STRB_W-1:0]     out_strb_q;
    logic [SEL_W-1:0]      out_sel_q;
    logic [SEL_W-1:0]      rr_ptr_q;

`ifdef HWPE_ARB_BURST_LOCK_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    logic                  lock_q;
    logic [SEL_W-1:0]      lock_idx_q;
    logic [CNT_W-1:0]      burst_cnt_q;
`endif

    // -------------------------------------------------------------------------
    // Combinational grant
    // -------------------------------------------------------------------------
    logic                  can_load;
    logic                  active;
    logic                  xfer;
    logic [N_INPUTS-1:0]   eligible;
    logic [N_INPUTS-1:0]   grant;
    logic                  grant_found;
    logic [SEL_W-1:0]      grant_idx;
    logic [DATA_WIDTH-1:0] win_data;
    logic [STRB_W-1:0]     win_strb;

    // Successor of a requester index, wrapping N_INPUTS-1 -> 0.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] k);
        if (N_INPUTS == 1) begin
            return '0;
        end
        return (k == SEL_W'(N_INPUTS - 1)) ? '0 : k + SEL_W'(1);
    endfunction

    assign can_load = ~out_valid_q | out_ready;
    assign active   = rst_n & ~clear;
    // Only a granted requester can be told ready, and never during reset/clear.
    assign in_ready = grant & {N_INPUTS{can_load & active}};
    assign xfer     = grant_found & can_load;

`ifdef HWPE_ARB_BURST_LOCK_EN
    // While locked, only the owner of the burst is allowed to compete.
    always_comb begin
        eligible = in_valid;
        if (lock_q) begin
            eligible = '0;
            eligible[lock_idx_q] = in_valid[lock_idx_q];
        end
    end
`else
    assign eligible = in_valid;
`endif

    // Scan rr_ptr, rr_ptr+1, ... (mod N_INPUTS); the first eligible input wins.
    always_comb begin : grant_scan
        int idx;
        // NOTE: every variable gets a default before the loop so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        win_data    = '0;
        win_strb    = '0;
        for (int off = 0; off < N_INPUTS; off++) begin
            idx = (int'(rr_ptr_q) + off) % N_INPUTS;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = SEL_W'(idx);
                win_data    = in_data[idx*DATA_WIDTH +: DATA_WIDTH];
                win_strb    = in_strb[idx*STRB_W +: STRB_W];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered output stage and arbitration state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset as well, because out_data,
        // out_strb and out_sel are visible ports with defined reset values.
        if (!rst_n || clear) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
`ifdef HWPE_ARB_BURST_LOCK_EN
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            burst_cnt_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register update based
            // on the values sampled at this edge, independent of statement order.
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= win_data;
                out_strb_q  <= win_strb;
                out_sel_q   <= grant_idx;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

`ifdef HWPE_ARB_BURST_LOCK_EN
            if (xfer) begin
                if (lock_q) begin
                    if (burst_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        lock_q      <= 1'b0;
                        burst_cnt_q <= '0;
                        rr_ptr_q    <= wrap_inc(lock_idx_q);
                    end else begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                    end
                end else if (BURST_LEN == 1) begin
                    // A one-beat burst releases on the beat that opened it.
                    rr_ptr_q <= wrap_inc(grant_idx);
                end else begin
                    // rr_ptr is ignored while locked; preloading it with the
                    // release value keeps the release path uniform.
                    lock_q      <= 1'b1;
                    lock_idx_q  <= grant_idx;
                    burst_cnt_q <= CNT_W'(1);
                    rr_ptr_q    <= wrap_inc(grant_idx);
                end
            end else if (lock_q && can_load && !in_valid[lock_idx_q]) begin
                // Owner went idle while a beat could have been taken: release.
                // A stall (can_load=0) never gets here.
                lock_q      <= 1'b0;
                burst_cnt_q <= '0;
                rr_ptr_q    <= wrap_inc(lock_idx_q);
            end
`else
            if (xfer) begin
                rr_ptr_q <= wrap_inc(grant_idx);
            end
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_strb  = out_strb_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_hwpe_stream_fifo_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for hwpe_stream_fifo_rr_arbiter (N_INPUTS=4, DATA_WIDTH=32,
// BURST_LEN=4). Works with and without HWPE_ARB_BURST_LOCK_EN defined.
//
// A behavioural model tracks the expected output register, pointer and burst
// lock. Every cycle the compare step checks in_ready and the registered
// outputs against it; directed sections add hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_hwpe_stream_fifo_rr_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int BL   = 4;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N*SW-1:0] in_strb;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_strb;
    logic [SELW-1:0] out_sel;

    always #5 clk = ~clk;

    hwpe_stream_fifo_rr_arbiter #(
        .N_INPUTS  (N),
        .DATA_WIDTH(DW),
        .BURST_LEN (BL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_strb  (in_strb),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_strb (out_strb),
        .out_sel  (out_sel)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    bit            m_known = 1'b0;
    bit            m_valid;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_strb;
    int            m_sel;
    int            m_ptr;
    bit            m_lock;
    int            m_lidx;
    int            m_cnt;
    logic [N-1:0]  m_acc = '0;

    // Winner by the rules: lock owner only, else first valid from the pointer.
    function automatic int exp_grant();
        if (m_lock) return in_valid[m_lidx] ? m_lidx : -1;
        for (int off = 0; off < N; off++)
            if (in_valid[(m_ptr + off) % N]) return (m_ptr + off) % N;
        return -1;
    endfunction

    // One clock cycle: compare at the falling edge, then advance the model.
    task automatic cycle();
        int           g;
        bit           can;
        logic [N-1:0] er;
        @(negedge clk);
        g   = exp_grant();
        can = !m_valid || out_ready;
        er  = '0;
        if (g >= 0 && can && rst_n && !clear) er[g] = 1'b1;
        check("in_ready", in_ready, er);
        if (m_known) begin
            check("out_valid", out_valid, m_valid);
            check("out_sel", out_sel, m_sel);
            check("out_data", out_data, m_data);
            check("out_strb", out_strb, m_strb);
        end
        m_acc = er;
        @(posedge clk);
        if (!rst_n || clear) begin
            m_known = 1'b1;
            m_valid = 1'b0; m_data = '0; m_strb = '0; m_sel = 0;
            m_ptr = 0; m_lock = 1'b0; m_lidx = 0; m_cnt = 0;
            m_acc = '0;
        end else begin
            if (er != '0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*DW +: DW];
                m_strb  = in_strb[g*SW +: SW];
                m_sel   = g;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
`ifdef HWPE_ARB_BURST_LOCK_EN
            if (er != '0) begin
                if (m_lock) begin
                    m_cnt++;
                    if (m_cnt == BL) begin
                        m_lock = 1'b0; m_cnt = 0; m_ptr = (m_lidx + 1) % N;
                    end
                end else if (BL == 1) begin
                    m_ptr = (g + 1) % N;
                end else begin
                    m_lock = 1'b1; m_lidx = g; m_cnt = 1;
                end
            end else if (m_lock && can && !in_valid[m_lidx]) begin
                m_lock = 1'b0; m_cnt = 0; m_ptr = (m_lidx + 1) % N;
            end
`else
            if (er != '0) m_ptr = (g + 1) % N;
`endif
        end
        #2;
    endtask

    task automatic set_slice(input int i, input logic [DW-1:0] d, input logic [SW-1:0] s);
        in_data[i*DW +: DW] = d;
        in_strb[i*SW +: SW] = s;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < N; i++) set_slice(i, 32'hD0D0_0000 + DW'(i), SW'(i + 1));
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        in_valid  = '1;
        in_data   = '0;
        in_strb   = '0;
        load_pattern();

        // Reset held two cycles with every requester valid.
        #1 check("rst_in_ready", in_ready, 4'b0000);
        cycle();
        cycle();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sel", out_sel, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        cycle();
        check("first_grant_valid", out_valid, 1'b1);
        check("first_grant_sel", out_sel, 0);
        check("first_grant_data", out_data, 32'hD0D0_0000);

        clear = 1'b1; cycle(); clear = 1'b0;

`ifndef HWPE_ARB_BURST_LOCK_EN
        // All valid: plain rotation 0,1,2,3,0,1 at one beat per cycle.
        begin
            int seq[6] = '{0, 1, 2, 3, 0, 1};
            for (int k = 0; k < 6; k++) begin
                cycle();
                check("rot_sel", out_sel, seq[k]);
                check("rot_data", out_data, 32'hD0D0_0000 + DW'(seq[k]));
                check("rot_valid", out_valid, 1'b1);
            end
        end

        // Only input 2, then inputs 1 and 2: pointer wraps 3 -> 0 -> 1.
        clear = 1'b1; cycle(); clear = 1'b0;
        in_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("solo2_sel", out_sel, 2);
        end
        in_valid = 4'b0110;
        cycle();
        check("wrap_sel1", out_sel, 1);
        cycle();
        check("wrap_sel2", out_sel, 2);
`else
        // Burst lock: 0,0,0,0 then 1,1; dropping input 1 releases to input 2.
        begin
            int seq[6] = '{0, 0, 0, 0, 1, 1};
            for (int k = 0; k < 6; k++) begin
                cycle();
                check("burst_sel", out_sel, seq[k]);
                check("burst_data", out_data, 32'hD0D0_0000 + DW'(seq[k]));
            end
        end
        in_valid[1] = 1'b0;
        cycle();
        check("burst_drop_valid", out_valid, 1'b0);
        cycle();
        check("burst_next_sel", out_sel, 2);
        in_valid[1] = 1'b1;
`endif

        // Backpressure: loaded beat held for five stalled cycles.
        clear = 1'b1; cycle(); clear = 1'b0;
        in_valid = 4'b0001;
        set_slice(0, 32'hA5A5_A5A5, 4'hF);
        set_slice(1, 32'h1111_2222, 4'h3);
        cycle();
        check("bp_load_sel", out_sel, 0);
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_data", out_data, 32'hA5A5_A5A5);
            #1 check("bp_in_ready", in_ready, 4'b0000);
        end
        out_ready = 1'b1;
        cycle();
`ifdef HWPE_ARB_BURST_LOCK_EN
        // Owner 0 is idle once the stall lifts: the lock drains first.
        check("bp_release_valid", out_valid, 1'b0);
        cycle();
`endif
        check("bp_next_sel", out_sel, 1);
        check("bp_next_data", out_data, 32'h1111_2222);

        // Clear mid-stream: everything returns to reset, nothing accepted.
        in_valid = '1;
        load_pattern();
        cycle();
        cycle();
        clear = 1'b1;
        #1 check("clr_in_ready", in_ready, 4'b0000);
        cycle();
        check("clr_out_valid", out_valid, 1'b0);
        check("clr_out_sel", out_sel, 0);
        clear = 1'b0;
        cycle();
        check("clr_first_sel", out_sel, 0);
        check("clr_first_valid", out_valid, 1'b1);

        // Randomised traffic honouring the hold-until-accepted rule.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || m_acc[i]) begin
                    in_valid[i] = ($urandom_range(0, 2) != 0);
                    set_slice(i, DW'($urandom()), SW'($urandom_range(0, 15)));
                end
`ifdef HWPE_ARB_BURST_LOCK_EN
                else if ($urandom_range(0, 15) == 0) begin
                    in_valid[i] = 1'b0;
                end
`endif
            end
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
